// File: rtl/sprite_draw_sequencer.sv
// Sprite draw sequencer: drains a queue of sprite jobs into SDRAM, one
// 128-bit row per write, masking transparent bytes via byte enables.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for new_frame
// S_FETCH  | pop next job (wait here while the queue is empty)
// S_RD     | sprite RAM read in flight; capture row on last latency cycle
// S_WR     | SDRAM write request / handshake
// S_NEXT   | advance row counter, start next read or finish job
// S_JOBEND | job finished; pulse done if it was the frame's last job
module sprite_draw_sequencer #(
  parameter int          FIFO_DEPTH  = 4,
  parameter int          LINE_STRIDE = 40,
  parameter int          RAM_LAT     = 1,
  parameter logic [7:0]  TRANSPARENT = 8'hFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          new_frame,
  input  logic          job_valid,
  output logic          job_ready,
  input  logic [8:0]    job_ram_base,
  input  logic [5:0]    job_rows,
  input  logic [21:0]   job_sdram_addr,
  input  logic          job_last,
  output logic [8:0]    ram_rdaddr,
  input  logic [127:0]  ram_q,
  output logic          sdram_wr,
  output logic [21:0]   sdram_addr,
  output logic [127:0]  sdram_data,
  output logic [15:0]   sdram_be,
  input  logic          sdram_wait,
  input  logic          sdram_ac,
  output logic          busy,
  output logic          done,
  output logic          frame_overrun
);

  localparam int         PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [1:0] LAT_LOAD = 2'(RAM_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_RD, S_WR, S_NEXT, S_JOBEND} state_t;
  state_t state, state_nxt;

  logic [8:0]     fifo_base [FIFO_DEPTH];
  logic [5:0]     fifo_rows [FIFO_DEPTH];
  logic [21:0]    fifo_addr [FIFO_DEPTH];
  logic           fifo_last [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic           full, empty, push, pop;

  logic [8:0]     head_base;
  logic [5:0]     head_rows;
  logic [21:0]    head_addr;
  logic           head_last;

  logic [8:0]     cur_base;
  logic [5:0]     cur_rows;
  logic [21:0]    cur_addr;
  logic           cur_last;
  logic [5:0]     row_cnt, row_nxt;
  logic [1:0]     lat_cnt;
  logic [21:0]    row_off;
  logic [15:0]    be_in;

  // Occupancy uses an extra wrap bit so full and empty are distinguishable;
  // job_ready reflects occupancy before any same-cycle pop.
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign job_ready = !full;
  assign push      = job_valid && !full;

  assign head_base = fifo_base[rd_ptr[PTR_W-1:0]];
  assign head_rows = fifo_rows[rd_ptr[PTR_W-1:0]];
  assign head_addr = fifo_addr[rd_ptr[PTR_W-1:0]];
  assign head_last = fifo_last[rd_ptr[PTR_W-1:0]];

  assign busy    = (state != S_IDLE);
  assign row_nxt = row_cnt + 6'd1;
  assign row_off = 22'(row_cnt) * 22'(LINE_STRIDE);

  // Byte enables: write every byte that is not the transparent colour.
  always_comb begin
    be_in = '0;
    for (int i = 0; i < 16; i++) be_in[i] = (ram_q[8*i +: 8] != TRANSPARENT);
  end

  // Job queue storage; flushing on reset is done through the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_base[wr_ptr[PTR_W-1:0]] <= job_ram_base;
      fifo_rows[wr_ptr[PTR_W-1:0]] <= job_rows;
      fifo_addr[wr_ptr[PTR_W-1:0]] <= job_sdram_addr;
      fifo_last[wr_ptr[PTR_W-1:0]] <= job_last;
    end
  end

  // Queue pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and queue pop.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE:   if (new_frame) state_nxt = S_FETCH;
      S_FETCH:  if (!empty) begin
                  pop       = 1'b1;
                  state_nxt = (head_rows == 6'd0) ? S_JOBEND : S_RD;
                end
      S_RD:     if (lat_cnt == 2'd0) state_nxt = (be_in == 16'd0) ? S_NEXT : S_WR;
      S_WR:     if (sdram_wr && sdram_ac) state_nxt = S_NEXT;
      S_NEXT:   state_nxt = (row_nxt == cur_rows) ? S_JOBEND : S_RD;
      S_JOBEND: state_nxt = cur_last ? S_IDLE : S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath: job registers, read address, write request and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_base      <= '0;
      cur_rows      <= '0;
      cur_addr      <= '0;
      cur_last      <= 1'b0;
      row_cnt       <= '0;
      lat_cnt       <= '0;
      ram_rdaddr    <= '0;
      sdram_wr      <= 1'b0;
      sdram_addr    <= '0;
      sdram_data    <= '0;
      sdram_be      <= '0;
      done          <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      done          <= 1'b0;
      frame_overrun <= new_frame && (state != S_IDLE);
      case (state)
        S_FETCH: if (!empty) begin
          cur_base <= head_base;
          cur_rows <= head_rows;
          cur_addr <= head_addr;
          cur_last <= head_last;
          row_cnt  <= '0;
          lat_cnt  <= LAT_LOAD;
          if (head_rows != 6'd0) ram_rdaddr <= head_base;
        end
        S_RD: begin
          if (lat_cnt == 2'd0) begin
            sdram_data <= ram_q;
            sdram_addr <= cur_addr + row_off;
            sdram_be   <= be_in;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        S_WR: begin
          if (!sdram_wr && !sdram_wait)   sdram_wr <= 1'b1;
          else if (sdram_wr && sdram_ac)  sdram_wr <= 1'b0;
        end
        S_NEXT: begin
          row_cnt <= row_nxt;
          if (row_nxt != cur_rows) begin
            ram_rdaddr <= cur_base + 9'(row_nxt);
            lat_cnt    <= LAT_LOAD;
          end
        end
        S_JOBEND: if (cur_last) done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// Directed bench for sprite_draw_sequencer (RAM_LAT = 1, combinational RAM
// model on the registered read address, programmable SDRAM accept delay).
module tb_sprite_draw_sequencer;

  logic          clk = 1'b0;
  logic          reset, new_frame, job_valid, job_ready, job_last;
  logic [8:0]    job_ram_base, ram_rdaddr;
  logic [5:0]    job_rows;
  logic [21:0]   job_sdram_addr, sdram_addr;
  logic [127:0]  ram_q, sdram_data;
  logic          sdram_wr, sdram_wait, sdram_ac, busy, done, frame_overrun;
  logic [15:0]   sdram_be;

  logic [127:0]  mem [512];
  logic [21:0]   wl_addr [$];
  logic [127:0]  wl_data [$];
  logic [15:0]   wl_be   [$];
  logic [8:0]    rd_log  [$];
  logic [8:0]    rd_prev;
  int            ac_delay, ac_cnt, done_cnt, ovr_cnt;
  int            errors = 0, checks = 0;

  always #5 clk = ~clk;

  assign ram_q = mem[ram_rdaddr];

  sprite_draw_sequencer dut (
    .clk(clk), .reset(reset), .new_frame(new_frame),
    .job_valid(job_valid), .job_ready(job_ready), .job_ram_base(job_ram_base),
    .job_rows(job_rows), .job_sdram_addr(job_sdram_addr), .job_last(job_last),
    .ram_rdaddr(ram_rdaddr), .ram_q(ram_q), .sdram_wr(sdram_wr),
    .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_be(sdram_be),
    .sdram_wait(sdram_wait), .sdram_ac(sdram_ac), .busy(busy), .done(done),
    .frame_overrun(frame_overrun)
  );

  // SDRAM responder and event monitors, all on the falling edge.
  always @(negedge clk) begin
    if (reset || !sdram_wr) begin
      ac_cnt   = 0;
      sdram_ac = 1'b0;
    end else begin
      sdram_ac = (ac_cnt >= ac_delay);
      ac_cnt++;
      if (sdram_ac) begin
        wl_addr.push_back(sdram_addr);
        wl_data.push_back(sdram_data);
        wl_be.push_back(sdram_be);
      end
    end
    if (done === 1'b1) done_cnt++;
    if (frame_overrun === 1'b1) ovr_cnt++;
    if (ram_rdaddr !== rd_prev) begin
      rd_log.push_back(ram_rdaddr);
      rd_prev = ram_rdaddr;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    wl_addr.delete(); wl_data.delete(); wl_be.delete(); rd_log.delete();
    done_cnt = 0; ovr_cnt = 0;
  endtask

  task automatic push_job(input logic [8:0] b, input logic [5:0] r,
                          input logic [21:0] a, input logic l);
    int n = 0;
    job_valid = 1'b1; job_ram_base = b; job_rows = r; job_sdram_addr = a; job_last = l;
    while (!job_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic pulse_nf();
    new_frame = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (done !== 1'b1 && n < max) begin @(negedge clk); n++; end
    chk(tag, done, 1'b1);
  endtask

  task automatic wait_wr(input string tag, input int max);
    int n = 0;
    while (sdram_wr !== 1'b1 && n < max) begin @(negedge clk); n++; end
    chk(tag, sdram_wr, 1'b1);
  endtask

  initial begin
    logic [127:0] row_c;
    reset = 1'b1; new_frame = 1'b0; job_valid = 1'b0; job_last = 1'b0;
    job_ram_base = '0; job_rows = '0; job_sdram_addr = '0;
    sdram_wait = 1'b0; sdram_ac = 1'b0; ac_delay = 0; ac_cnt = 0;
    done_cnt = 0; ovr_cnt = 0; rd_prev = '0;
    for (int i = 0; i < 512; i++) mem[i] = {4{32'h1000_0000 + 32'(i)}};
    mem[9'h020] = {16{8'hFF}};
    mem[9'h021] = {64'h0011_2233_4455_6677, 64'hFFFF_FFFF_FFFF_FFFF};

    // reset state
    tick(3);
    reset = 1'b0;
    chk("rst_wr", sdram_wr, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovr", frame_overrun, 1'b0);
    chk("rst_rdaddr", ram_rdaddr, 9'h0);
    chk("rst_addr", sdram_addr, 22'h0);
    chk("rst_data", sdram_data, 128'h0);
    chk("rst_be", sdram_be, 16'h0);
    chk("rst_ready", job_ready, 1'b1);

    // basic job: two rows, stride 40 words
    clear_logs();
    push_job(9'h010, 6'd2, 22'h000100, 1'b1);
    pulse_nf();
    wait_done("basic_done", 60);
    chk("basic_busy_low_with_done", busy, 1'b0);
    tick(3);
    chk("basic_nwr", wl_addr.size(), 2);
    chk("basic_addr0", wl_addr[0], 22'h000100);
    chk("basic_addr1", wl_addr[1], 22'h000128);
    chk("basic_data0", wl_data[0], mem[9'h010]);
    chk("basic_data1", wl_data[1], mem[9'h011]);
    chk("basic_be0", wl_be[0], 16'hFFFF);
    chk("basic_nrd", rd_log.size(), 2);
    chk("basic_rd0", rd_log[0], 9'h010);
    chk("basic_rd1", rd_log[1], 9'h011);
    chk("basic_done_cnt", done_cnt, 1);

    // transparency: row 0 fully transparent, row 1 half transparent
    clear_logs();
    push_job(9'h020, 6'd2, 22'h001000, 1'b1);
    pulse_nf();
    wait_done("transp_done", 60);
    tick(2);
    chk("transp_nwr", wl_addr.size(), 1);
    chk("transp_addr", wl_addr[0], 22'h001028);
    chk("transp_be", wl_be[0], 16'hFF00);
    chk("transp_data", wl_data[0], mem[9'h021]);

    // handshake: wait holds off the request; request stable until accept
    clear_logs();
    row_c = mem[9'h030];
    sdram_wait = 1'b1;
    push_job(9'h030, 6'd1, 22'h002000, 1'b1);
    pulse_nf();
    tick(14);
    chk("hs_wr_held_off", sdram_wr, 1'b0);
    chk("hs_busy", busy, 1'b1);
    ac_delay = 5;
    sdram_wait = 1'b0;
    wait_wr("hs_wr_rise", 10);
    sdram_wait = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("hs_wr_stable", sdram_wr, 1'b1);
      chk("hs_addr_stable", sdram_addr, 22'h002000);
      chk("hs_data_stable", sdram_data, row_c);
      chk("hs_be_stable", sdram_be, 16'hFFFF);
      @(negedge clk);
    end
    sdram_wait = 1'b0;
    wait_done("hs_done", 20);
    tick(2);
    chk("hs_nwr", wl_addr.size(), 1);
    ac_delay = 0;

    // queue full: five jobs offered back-to-back in IDLE
    clear_logs();
    for (int j = 0; j < 4; j++)
      push_job(9'h040 + 9'(j), 6'd1, 22'h010000 + 22'(j * 'h100), 1'b0);
    chk("full_ready_low", job_ready, 1'b0);
    job_valid = 1'b1; job_ram_base = 9'h044; job_rows = 6'd1;
    job_sdram_addr = 22'h010400; job_last = 1'b1;
    tick(3);
    chk("full_still_blocked", job_ready, 1'b0);
    chk("full_idle", busy, 1'b0);
    pulse_nf();
    begin
      int n = 0;
      while (!job_ready && n < 10) begin @(negedge clk); n++; end
      chk("full_ready_after_pop", job_ready, 1'b1);
    end
    @(negedge clk);
    job_valid = 1'b0; job_last = 1'b0;
    wait_done("full_done", 100);
    tick(2);
    chk("full_nwr", wl_addr.size(), 5);
    chk("full_addr0", wl_addr[0], 22'h010000);
    chk("full_addr4", wl_addr[4], 22'h010400);
    chk("full_data4", wl_data[4], mem[9'h044]);

    // zero-row job then a one-row job, with a second new_frame mid-write
    clear_logs();
    ac_delay = 3;
    push_job(9'h050, 6'd0, 22'h003000, 1'b0);
    push_job(9'h051, 6'd1, 22'h003100, 1'b1);
    pulse_nf();
    wait_wr("zr_wr_rise", 20);
    pulse_nf();
    wait_done("zr_done", 30);
    tick(3);
    chk("zr_nwr", wl_addr.size(), 1);
    chk("zr_addr", wl_addr[0], 22'h003100);
    chk("zr_nrd", rd_log.size(), 1);
    chk("zr_rd0", rd_log[0], 9'h051);
    chk("zr_ovr_cnt", ovr_cnt, 1);
    chk("zr_done_cnt", done_cnt, 1);

    // reset in the middle of a write
    clear_logs();
    ac_delay = 100;
    push_job(9'h060, 6'd1, 22'h004000, 1'b1);
    pulse_nf();
    wait_wr("rm_wr_rise", 20);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rm_wr", sdram_wr, 1'b0);
    chk("rm_busy", busy, 1'b0);
    chk("rm_ready", job_ready, 1'b1);
    ac_delay = 0;
    clear_logs();
    pulse_nf();
    tick(10);
    chk("rm_parked_busy", busy, 1'b1);
    chk("rm_no_write", sdram_wr, 1'b0);
    chk("rm_nwr", wl_addr.size(), 0);
    chk("rm_no_done", done_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
